// File: rtl/adc_seq_sched_pkg.sv
// Shared types for the ADC conversion scheduler: FSM states, owner tag, widths.
// next_set() finds the first enabled scan channel at or after a start index.
package adc_sched_pkg;

   localparam int ADC_W = 12;
   localparam int CH_W  = 3;
   localparam int IDX_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      START,
      WAIT,
      STORE
   } sched_state_t;

   typedef struct packed {
      logic             is_scan;
      logic [IDX_W-1:0] idx;
   } owner_t;

   function automatic logic [CH_W-1:0] next_set(input logic [(1<<CH_W)-1:0] mask,
                                                input logic [CH_W-1:0]      start);
      logic [CH_W-1:0] c;
      next_set = start;
      // Walk downward so the closest set bit (smallest offset) is the last one kept.
      for (int i = (1 << CH_W) - 1; i >= 0; i--) begin
         c = start + CH_W'(i);
         if (mask[c]) next_set = c;
      end
   endfunction

endpackage

// File: rtl/adc_seq_sched_if.sv
// Client request/ack bus plus converter start/done handshake.
// master = scheduler side, slave = clients + ADC serial controller side.
interface adc_seq_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]                               req;
   logic [NREQ-1:0][adc_sched_pkg::CH_W-1:0]      req_ch;
   logic [NREQ-1:0]                               ack;
   logic [adc_sched_pkg::ADC_W-1:0]               rslt;
   logic                                          conv_start;
   logic [adc_sched_pkg::CH_W-1:0]                conv_ch;
   logic                                          conv_busy;
   logic                                          conv_done;
   logic [adc_sched_pkg::ADC_W-1:0]               conv_data;

   modport master (
      input  req, req_ch, conv_busy, conv_done, conv_data,
      output ack, rslt, conv_start, conv_ch
   );

   modport slave (
      output req, req_ch, conv_busy, conv_done, conv_data,
      input  ack, rslt, conv_start, conv_ch
   );
endinterface

// File: rtl/adc_seq_sched_rr_arbiter.sv
// Rotating-priority arbiter, one-hot grant, combinational; priority starts after the last advanced grant.
// adv moves the pointer past the current winner; with no request the pointer holds.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] k;
   logic          any;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      k       = '0;
      for (int i = N - 1; i >= 0; i--) begin
         k = IW'((int'(ptr_q) + i) % N);
         if (req[k]) begin
            gnt_idx = k;
            any     = 1'b1;
         end
      end
      if (any) gnt[gnt_idx] = 1'b1;

      ptr_d = ptr_q;
      if (adv && any) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/adc_seq_sched.sv
// Arbitrates one-shot client conversions and a background channel scan onto one serial ADC.
// req->conv_start 3 cycles min; conv_done->ack 1 cycle; stalls in START while conv_busy, aborts after TIMEOUT.
module adc_seq_sched
   import adc_sched_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int NCH      = 8,
   parameter int SCAN_DIV = 2500,
   parameter int TIMEOUT  = 4095
) (
   input  logic                       clk,
   input  logic                       rst,
   adc_seq_sched_if.master            bus,
   input  logic                       scan_en,
   input  logic [NCH-1:0]             scan_mask,
   output logic [NCH-1:0][ADC_W-1:0]  chan_data,
   output logic [NCH-1:0]             chan_fresh,
   input  logic [NCH-1:0]             chan_clr,
   output logic                       err_timeout
);

   localparam int CIW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   sched_state_t              state_q, state_d;
   owner_t                    owner_q, owner_d;
   logic [CH_W-1:0]           conv_ch_q, conv_ch_d;
   logic                      conv_start_q, conv_start_d;
   logic [NREQ-1:0]           ack_q, ack_d;
   logic [ADC_W-1:0]          rslt_q, rslt_d;
   logic [NCH-1:0][ADC_W-1:0] data_q, data_d;
   logic [NCH-1:0]            fresh_q, fresh_d;
   logic                      err_q, err_d;
   logic [CH_W-1:0]           scan_ptr_q, scan_ptr_d;
   logic [TICK_W-1:0]         tick_q, tick_d;
   logic                      pend_q, pend_d;
   logic [TMO_W-1:0]          tmo_q, tmo_d;
   logic                      tick_hit;

   logic [NREQ-1:0]           rr_gnt;
   logic [CIW-1:0]            rr_idx;
   logic                      rr_adv;

   rr_arbiter #(.N(NREQ)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req),
      .adv     (rr_adv),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      conv_ch_d    = conv_ch_q;
      conv_start_d = 1'b0;
      ack_d        = '0;
      rslt_d       = rslt_q;
      data_d       = data_q;
      fresh_d      = fresh_q & ~chan_clr;
      err_d        = err_q;
      scan_ptr_d   = scan_ptr_q;
      tmo_d        = tmo_q;
      rr_adv       = 1'b0;
      pend_d       = pend_q;
      tick_hit     = (tick_q == TICK_W'(SCAN_DIV - 1));
      tick_d       = tick_hit ? '0 : tick_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (|rr_gnt) begin
               owner_d = '{is_scan: 1'b0, idx: IDX_W'(rr_idx)};
               rr_adv  = 1'b1;
               state_d = GRANT;
            end else if (scan_en && pend_q && (|scan_mask)) begin
               owner_d = '{is_scan: 1'b1, idx: IDX_W'(next_set(scan_mask, scan_ptr_q))};
               pend_d  = 1'b0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            conv_ch_d = owner_q.is_scan ? owner_q.idx[CH_W-1:0]
                                        : bus.req_ch[owner_q.idx[CIW-1:0]];
            state_d   = START;
         end
         START: begin
            if (!bus.conv_busy) begin
               conv_start_d = 1'b1;
               tmo_d        = '0;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (bus.conv_done) begin
               state_d = STORE;
               if (owner_q.is_scan) begin
                  data_d[conv_ch_q]  = bus.conv_data;
                  fresh_d[conv_ch_q] = 1'b1;
                  scan_ptr_d         = conv_ch_q + 1'b1;
               end else begin
                  ack_d[owner_q.idx[CIW-1:0]] = 1'b1;
                  rslt_d                      = bus.conv_data;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT)) begin
               // Abandoned client keeps its req up and is simply re-arbitrated.
               err_d   = 1'b1;
               state_d = IDLE;
               if (owner_q.is_scan) scan_ptr_d = conv_ch_q + 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         STORE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (tick_hit) pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         conv_ch_q    <= '0;
         conv_start_q <= 1'b0;
         ack_q        <= '0;
         rslt_q       <= '0;
         data_q       <= '0;
         fresh_q      <= '0;
         err_q        <= 1'b0;
         scan_ptr_q   <= '0;
         tick_q       <= '0;
         pend_q       <= 1'b0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         conv_ch_q    <= conv_ch_d;
         conv_start_q <= conv_start_d;
         ack_q        <= ack_d;
         rslt_q       <= rslt_d;
         data_q       <= data_d;
         fresh_q      <= fresh_d;
         err_q        <= err_d;
         scan_ptr_q   <= scan_ptr_d;
         tick_q       <= tick_d;
         pend_q       <= pend_d;
         tmo_q        <= tmo_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.rslt       = rslt_q;
   assign bus.conv_start = conv_start_q;
   assign bus.conv_ch    = conv_ch_q;
   assign chan_data      = data_q;
   assign chan_fresh     = fresh_q;
   assign err_timeout    = err_q;

endmodule

// File: tb/tb_adc_seq_sched.sv
// Directed bench for adc_seq_sched: single client, fairness, scan table, priority, timeout, reset mid-conversion.
module tb_adc_seq_sched;
   import adc_sched_pkg::*;

   localparam int NREQ     = 4;
   localparam int NCH      = 8;
   localparam int SCAN_DIV = 10;
   localparam int TIMEOUT  = 4095;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      scan_en = 1'b0;
   logic [NCH-1:0]            scan_mask = '0;
   logic [NCH-1:0]            chan_clr = '0;
   logic [NCH-1:0]            chan_fresh;
   logic [NCH-1:0][ADC_W-1:0] chan_data;
   logic                      err_timeout;

   int n_chk = 0;
   int n_pass = 0;
   int ack_cnt = 0;
   int start_cnt = 0;
   int sc_ch[4] = '{0, 2, 7, 0};

   adc_seq_sched_if #(.NREQ(NREQ)) bus ();

   adc_seq_sched #(
      .NREQ(NREQ), .NCH(NCH), .SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .scan_en     (scan_en),
      .scan_mask   (scan_mask),
      .chan_data   (chan_data),
      .chan_fresh  (chan_fresh),
      .chan_clr    (chan_clr),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (|bus.ack)       ack_cnt   <= ack_cnt + 1;
      if (bus.conv_start) start_cnt <= start_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.conv_done = 1'b0;
      scan_en = 1'b0;
      scan_mask = '0;
      chan_clr = '0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(output logic ok, output logic [CH_W-1:0] ch, output int lat);
      ok = 1'b0;
      ch = '0;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         if (!ok) begin
            tick();
            if (bus.conv_start) begin
               ok = 1'b1;
               ch = bus.conv_ch;
               lat = i;
            end
         end
      end
   endtask

   // Waits for a start, lets the converter run dly cycles, then returns after the done edge.
   task automatic convert(input logic [ADC_W-1:0] d, input int dly, output logic ok,
                          output logic [CH_W-1:0] ch);
      int lat;
      wait_start(ok, ch, lat);
      repeat (dly) tick();
      bus.conv_done = 1'b1;
      bus.conv_data = d;
      tick();
      bus.conv_done = 1'b0;
   endtask

   initial begin
      logic            ok;
      logic [CH_W-1:0] ch;
      int              lat;
      int              a0, s0;

      bus.req = '0;
      bus.req_ch = '0;
      bus.conv_busy = 1'b0;
      bus.conv_done = 1'b0;
      bus.conv_data = '0;

      do_reset();
      check("rst_ack", bus.ack, 0);
      check("rst_rslt", bus.rslt, 0);
      check("rst_start", bus.conv_start, 0);
      check("rst_ch", bus.conv_ch, 0);
      check("rst_fresh", chan_fresh, 0);
      check("rst_err", err_timeout, 0);
      check("rst_data", |chan_data, 0);

      // Single client
      s0 = start_cnt;
      bus.req_ch[0] = 3'd5;
      bus.req = 4'b0001;
      wait_start(ok, ch, lat);
      check("t1_start", ok, 1);
      check("t1_lat", lat, 3);
      check("t1_ch", ch, 5);
      repeat (20) tick();
      check("t1_ch_hold", bus.conv_ch, 5);
      bus.conv_done = 1'b1;
      bus.conv_data = 12'hABC;
      tick();
      bus.conv_done = 1'b0;
      check("t1_ack", bus.ack, 4'b0001);
      check("t1_rslt", bus.rslt, 12'hABC);
      bus.req = '0;
      tick();
      check("t1_ack_pulse", bus.ack, 0);
      repeat (10) tick();
      check("t1_nstart", start_cnt - s0, 1);

      // Fairness: all four hold req
      do_reset();
      for (int c = 0; c < NREQ; c++) bus.req_ch[c] = CH_W'(c + 1);
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         convert(ADC_W'(12'h100 + k), 2, ok, ch);
         check($sformatf("fair_ch%0d", k), ch, (k % 4) + 1);
         check($sformatf("fair_ack%0d", k), bus.ack, 32'(1 << (k % 4)));
         check($sformatf("fair_rslt%0d", k), bus.rslt, 12'h100 + k);
         if (k == 4) bus.req = '0;
      end

      // Background scan
      do_reset();
      scan_mask = 8'b1000_0101;
      scan_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         convert(ADC_W'(12'h200 + k), 3, ok, ch);
         check($sformatf("scan_ok%0d", k), ok, 1);
         check($sformatf("scan_ch%0d", k), ch, sc_ch[k]);
         if (k == 2) begin
            check("scan_fresh3", chan_fresh, 8'b1000_0101);
            check("scan_d2", chan_data[2], 12'h201);
            check("scan_d7", chan_data[7], 12'h202);
         end
         if (k == 3) scan_en = 1'b0;
      end
      check("scan_d0", chan_data[0], 12'h203);
      check("scan_noack", bus.ack, 0);
      chan_clr = 8'b0000_0100;
      tick();
      chan_clr = '0;
      check("scan_clr2", chan_fresh, 8'b1000_0001);

      // Priority: pending tick and req[3] seen together
      do_reset();
      repeat (15) tick();
      scan_mask = 8'b0000_0010;
      scan_en = 1'b1;
      bus.req_ch[3] = 3'd6;
      bus.req = 4'b1000;
      convert(12'h333, 2, ok, ch);
      check("pri_ch_client", ch, 6);
      check("pri_ack", bus.ack, 4'b1000);
      bus.req = '0;
      convert(12'h444, 2, ok, ch);
      check("pri_ch_scan", ch, 1);
      check("pri_fresh", chan_fresh, 8'b0000_0010);
      check("pri_d1", chan_data[1], 12'h444);
      scan_en = 1'b0;

      // Timeout
      do_reset();
      a0 = ack_cnt;
      bus.req_ch[1] = 3'd3;
      bus.req = 4'b0010;
      wait_start(ok, ch, lat);
      check("tmo_start", ok, 1);
      repeat (TIMEOUT) tick();
      check("tmo_err_early", err_timeout, 0);
      tick();
      check("tmo_err", err_timeout, 1);
      check("tmo_noack", ack_cnt - a0, 0);
      wait_start(ok, ch, lat);
      check("tmo_regrant", ok, 1);
      check("tmo_regrant_lat", lat, 3);
      check("tmo_regrant_ch", ch, 3);
      bus.conv_done = 1'b1;
      bus.conv_data = 12'h5A5;
      tick();
      bus.conv_done = 1'b0;
      check("tmo_ack", bus.ack, 4'b0010);
      bus.req = '0;
      tick();
      check("tmo_sticky", err_timeout, 1);

      // Reset mid-WAIT, then a late done
      do_reset();
      check("rst2_err", err_timeout, 0);
      bus.req_ch[2] = 3'd4;
      bus.req = 4'b0100;
      wait_start(ok, ch, lat);
      check("rst2_start", ok, 1);
      repeat (5) tick();
      a0 = ack_cnt;
      s0 = start_cnt;
      rst = 1'b1;
      bus.req = '0;
      repeat (2) tick();
      rst = 1'b0;
      bus.conv_done = 1'b1;
      bus.conv_data = 12'hFFF;
      tick();
      bus.conv_done = 1'b0;
      repeat (5) tick();
      check("rst2_noack", ack_cnt - a0, 0);
      check("rst2_nostart", start_cnt - s0, 0);
      check("rst2_ack", bus.ack, 0);
      check("rst2_rslt", bus.rslt, 0);
      check("rst2_ch", bus.conv_ch, 0);
      check("rst2_data", |chan_data, 0);
      check("rst2_fresh", chan_fresh, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
